mips_multicycle_controller: RTL and testbench

Control unit for the MIPS datapath. Consumes the decoded OPC/Func fields and the ALU zero flag, and drives every datapath control input: Jsel, Jrsel, regwrite, RegDst, ALUsrc, PCSrc, ALU_operation, MemRead, MemWrite, MemToReg. It sequences each instruction through a multi-cycle FSM. A pc_write strobe gates the datapath PC register, which loads only when pc_write=1.

---
 rtl/mips_ctrl_pkg.sv | 35 +++
 rtl/mips_alu_decoder.sv | 34 +++
 rtl/mips_multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle controller: opcodes, R-type funcs,
// ALU operation codes and FSM state encoding.
package mips_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational decode of the latched instruction fields into an ALU operation
// code and a legality flag; unsupported opcode/func combinations clear is_legal.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] ir_opc,
    input  logic [5:0] ir_func,
    output logic [2:0] alu_op,
    output logic       is_legal
);

    always_comb begin
        alu_op   = ALU_ADD;
        is_legal = 1'b1;
        case (ir_opc)
            OPC_RTYPE: begin
                case (ir_func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_JR:   alu_op = ALU_ADD;
                    default: is_legal = 1'b0;
                endcase
            end
            OPC_ADDI, OPC_LW, OPC_SW, OPC_J, OPC_JAL: alu_op = ALU_ADD;
            OPC_SLTI: alu_op = ALU_SLT;
            OPC_BEQ:  alu_op = ALU_SUB;
            default:  is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving all datapath controls.
// Optional PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OPC,
    input  logic [5:0]       Func,
    input  logic             zero,
    output logic             Jsel,
    output logic             Jrsel,
    output logic             regwrite,
    output logic             RegDst,
    output logic             ALUsrc,
    output logic             PCSrc,
    output logic [2:0]       ALU_operation,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             pc_write,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
`endif
    output logic             illegal
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_t     state_q, state_d;
    logic [5:0] ir_opc_q, ir_opc_d;
    logic [5:0] ir_func_q, ir_func_d;
    logic [2:0] dec_alu_op;
    logic       dec_legal;

    mips_alu_decoder u_alu_dec (
        .ir_opc   (ir_opc_q),
        .ir_func  (ir_func_q),
        .alu_op   (dec_alu_op),
        .is_legal (dec_legal)
    );

    logic is_rtype, is_jr, is_lw, is_sw, is_beq, uses_imm;
    assign is_rtype = (ir_opc_q == OPC_RTYPE);
    assign is_jr    = is_rtype && (ir_func_q == FN_JR);
    assign is_lw    = (ir_opc_q == OPC_LW);
    assign is_sw    = (ir_opc_q == OPC_SW);
    assign is_beq   = (ir_opc_q == OPC_BEQ);
    assign uses_imm = (ir_opc_q == OPC_ADDI) || (ir_opc_q == OPC_SLTI) || is_lw || is_sw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_opc_q  <= '0;
            ir_func_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_opc_q  <= ir_opc_d;
            ir_func_q <= ir_func_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ir_opc_d      = ir_opc_q;
        ir_func_d     = ir_func_q;
        Jsel          = 1'b0;
        Jrsel         = 1'b0;
        regwrite      = 1'b0;
        RegDst        = 1'b0;
        ALUsrc        = 1'b0;
        PCSrc         = 1'b0;
        ALU_operation = 3'b000;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemToReg      = 1'b0;
        pc_write      = 1'b0;
        illegal       = 1'b0;

        // Datapath selects are held constant from EXEC to the last state of the instruction.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            ALU_operation = dec_alu_op;
            ALUsrc        = uses_imm;
            RegDst        = is_rtype;
            MemToReg      = !is_lw;
        end

        case (state_q)
            S_FETCH: begin
                ir_opc_d  = OPC;
                ir_func_d = Func;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    illegal  = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else if (ir_opc_q == OPC_J || ir_opc_q == OPC_JAL) begin
                    Jsel     = 1'b1;
                    regwrite = (ir_opc_q == OPC_JAL);
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_jr) begin
                    Jrsel    = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    PCSrc    = zero;
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d  = S_MEM;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    MemWrite = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    MemRead  = 1'b1;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                MemRead  = is_lw;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    // Illegal instructions still pulse pc_write but do not count as retired.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
        retired_cnt_d = retired_cnt_q;
        if (pc_write && !illegal) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed plus randomized bench for the MIPS multicycle controller against a
// per-instruction, per-cycle behavioural expectation model.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OPC, Func;
    logic       zero;
    logic       Jsel, Jrsel, regwrite, RegDst, ALUsrc, PCSrc;
    logic [2:0] ALU_operation;
    logic       MemRead, MemWrite, MemToReg, pc_write, illegal;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int tests = 0;
    int fails = 0;

    mips_multicycle_controller #(.CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .OPC           (OPC),
        .Func          (Func),
        .zero          (zero),
        .Jsel          (Jsel),
        .Jrsel         (Jrsel),
        .regwrite      (regwrite),
        .RegDst        (RegDst),
        .ALUsrc        (ALUsrc),
        .PCSrc         (PCSrc),
        .ALU_operation (ALU_operation),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemToReg      (MemToReg),
        .pc_write      (pc_write),
`ifdef PERF_CNT_EN
        .cycle_cnt     (cycle_cnt),
        .retired_cnt   (retired_cnt),
`endif
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    wire [13:0] obs = {Jsel, Jrsel, regwrite, RegDst, ALUsrc, PCSrc, ALU_operation,
                       MemRead, MemWrite, MemToReg, pc_write, illegal};

    // Instruction classification straight from the ISA table.
    function automatic int classify(input logic [5:0] opc, input logic [5:0] fn);
        // 0 illegal, 1 R-alu, 2 jr, 3 addi, 4 slti, 5 lw, 6 sw, 7 beq, 8 j, 9 jal
        if (opc == 6'd0) begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a) return 1;
            if (fn == 6'h08) return 2;
            return 0;
        end
        case (opc)
            6'h08: return 3;
            6'h0a: return 4;
            6'h23: return 5;
            6'h2b: return 6;
            6'h04: return 7;
            6'h02: return 8;
            6'h03: return 9;
            default: return 0;
        endcase
    endfunction

    function automatic int latency(input int c);
        case (c)
            0, 2, 8, 9: return 2;
            7:          return 3;
            5:          return 5;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [2:0] alu_code(input int c, input logic [5:0] fn);
        if (c == 1) begin
            case (fn)
                6'h22:   return 3'b110;
                6'h24:   return 3'b000;
                6'h25:   return 3'b001;
                6'h2a:   return 3'b111;
                default: return 3'b010;
            endcase
        end
        if (c == 4) return 3'b111;
        if (c == 7) return 3'b110;
        return 3'b010;
    endfunction

    // Expected control bundle on cycle k (1 = fetch) of an instruction.
    function automatic logic [13:0] expect_out(input logic [5:0] opc, input logic [5:0] fn,
                                               input logic z, input int k);
        int   c;
        logic fin, sel;
        logic [2:0] alu;
        c   = classify(opc, fn);
        fin = (k == latency(c));
        sel = (k >= 3);
        alu = sel ? alu_code(c, fn) : 3'b000;
        return {fin && (c == 8 || c == 9),
                fin && (c == 2),
                fin && (c == 9 || c == 1 || c == 3 || c == 4 || c == 5),
                sel && (c == 1 || c == 2),
                sel && (c == 3 || c == 4 || c == 5 || c == 6),
                fin && (c == 7) && z,
                alu,
                (c == 5) && (k >= 4),
                fin && (c == 6),
                sel && (c != 5),
                fin,
                fin && (c == 0)};
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Runs one instruction from FETCH; zsel 0/1 forces zero, 2 randomizes it.
    // abort_at > 0 asserts reset at that cycle instead of completing.
    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int zsel,
                             input int abort_at, input string tag);
        int n;
        n = latency(classify(opc, fn));
        for (int k = 1; k <= n; k++) begin
            OPC  = (k == 1) ? opc : 6'($urandom);
            Func = (k == 1) ? fn  : 6'($urandom);
            zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check($sformatf("%s_rst_async", tag), 64'(obs), 64'd0);
                @(posedge clk); #1;
                check($sformatf("%s_rst_held", tag), 64'(obs), 64'd0);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, k), 64'(obs), 64'(expect_out(opc, fn, zero, k)));
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] tab_opc [12];
    logic [5:0] tab_fn  [12];

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab_opc = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h02};
        tab_fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        rst  = 1'b1;
        OPC  = 6'h00;
        Func = 6'h00;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(obs), 64'd0);
        rst = 1'b0;

        run_instr(6'h00, 6'h20, 2, 0, "add");
        run_instr(6'h23, 6'h15, 2, 0, "lw");
        run_instr(6'h02, 6'h3f, 2, 0, "j");
        run_instr(6'h3f, 6'h20, 2, 0, "ill_opc");
`ifdef PERF_CNT_EN
        check("retired_cnt", 64'(retired_cnt), 64'd3);
        check("cycle_cnt", 64'(cycle_cnt), 64'd13);
`endif
        run_instr(6'h2b, 6'h00, 2, 0, "sw");
        run_instr(6'h04, 6'h00, 1, 0, "beq_z1");
        run_instr(6'h04, 6'h00, 0, 0, "beq_z0");
        run_instr(6'h03, 6'h00, 2, 0, "jal");
        run_instr(6'h00, 6'h08, 2, 0, "jr");
        run_instr(6'h00, 6'h21, 2, 0, "ill_func");
        run_instr(6'h00, 6'h2a, 2, 0, "slt");
        run_instr(6'h0a, 6'h11, 2, 0, "slti");
        run_instr(6'h00, 6'h20, 2, 4, "add_abort");
        run_instr(6'h00, 6'h22, 2, 0, "sub_after_rst");

        for (int i = 0; i < 200; i++) begin
            logic [5:0] o, f;
            int idx;
            if ($urandom_range(3) == 0) begin
                o = 6'($urandom);
                f = 6'($urandom);
            end else begin
                idx = $urandom_range(11);
                o = tab_opc[idx];
                f = (o == 6'h00) ? tab_fn[idx] : 6'($urandom);
            end
            run_instr(o, f, 2, 0, $sformatf("rnd%0d_%h_%h", i, o, f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
